fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Consumer and driver of the program counter register.
- Reads the current PC, issues an instruction-memory read, and holds the returned instruction for decode under a valid/ready handshake.
- Computes the next PC (sequential step or branch redirect) and drives the PC register's update strobe and next-value inputs.
- Sits between the PC register, instruction memory and the decode stage of the multi-cycle CPU.

Parameters:
- ADDR_W, 32, PC/address width.
- INSTR_W, 32, instruction width.
- PC_INC, 4, sequential PC increment.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- pc_cur  in  ADDR_W  current PC from the PC register output.
- upd_pc  out  1  PC update strobe to the PC register.
- pc_next  out  ADDR_W  next PC value to the PC register.
- imem_req  out  1  instruction memory read request.
- imem_addr  out  ADDR_W  read address.
- imem_ack  in  1  read data valid (single-cycle pulse).
- imem_rdata  in  INSTR_W  read data.
- instr  out  INSTR_W  held instruction.
- instr_pc  out  ADDR_W  PC of the held instruction.
- instr_valid  out  1  instruction available to decode.
- instr_ready  in  1  decode accepts the instruction.
- br_taken  in  1  redirect pulse from execute.
- br_target  in  ADDR_W  redirect address.
- halt  in  1  stop fetching.
- halted  out  1  unit is halted.

Behaviour:
- States: REQ, WAIT, HOLD, DRAIN, HALTED. Reset state is REQ.
- Reset values: upd_pc=0, pc_next=0, imem_req=0, instr=0, instr_pc=0, instr_valid=0, halted=0.
- REQ:
  - imem_req=1, imem_addr=pc_cur for one cycle.
  - Next state WAIT; if imem_ack arrives in the same cycle, go directly to HOLD.
- WAIT:
  - imem_req=0; wait for imem_ack, any number of cycles.
  - On ack: capture instr<=imem_rdata and instr_pc<=imem_addr latched at REQ, then go to HOLD.
- HOLD:
  - instr_valid=1; instr and instr_pc stable until accepted.
  - Handshake on instr_valid && instr_ready: upd_pc=1 (combinational, same cycle) and pc_next=pc_cur+PC_INC.
  - After handshake: go to REQ, or to HALTED if halt is high.
- upd_pc timing:
  - upd_pc is high for exactly one cycle per PC change.
  - The PC register loads on the following edge, so the next REQ sees the new pc_cur.
  - Latency from handshake to next imem_req is 1 cycle.
- Branch redirect (br_taken=1, any state except HALTED):
  - upd_pc=1, pc_next=br_target; br_target overrides the +PC_INC value.
  - HOLD with handshake in the same cycle: the instruction counts as accepted; pc_next=br_target; go to REQ.
  - HOLD without handshake: instr_valid drops next cycle (held instruction flushed); go to REQ.
  - WAIT, no ack this cycle: go to DRAIN, discard the pending response; on ack go to REQ.
  - WAIT with ack in the same cycle: response discarded; go to REQ.
  - REQ: request already issued, go to DRAIN.
- halt:
  - Sampled only at handshake or while in REQ; in REQ, go to HALTED without issuing a request.
  - HALTED: halted=1, no requests, upd_pc=0, br_taken ignored. Exit only via rst.
- Arithmetic: pc_cur+PC_INC is modulo 2^ADDR_W; 0xFFFFFFFC+4 wraps to 0.
- imem_ack outside WAIT/DRAIN (or REQ same-cycle) is ignored.
- rst mid-operation:
  - Immediate return to reset values and REQ.
  - Any outstanding memory response after reset is ignored until the first REQ is issued.

Optional Feature:
- FETCH_STATS_EN defined: adds outputs fetch_count[31:0] and stall_count[31:0].
  - fetch_count increments per handshake.
  - stall_count increments per cycle in WAIT or DRAIN, or in HOLD with instr_ready=0.
  - Both saturate at 0xFFFFFFFF and reset to 0.
- Undefined: ports and counters absent; functionality otherwise identical.

Decomposition:
- Package fetch_pkg: state enum (REQ, WAIT, HOLD, DRAIN, HALTED), default PC_INC, ADDR_W, INSTR_W constants.
- Optional sub-module fetch_stats holds the saturating counters; instantiated only under FETCH_STATS_EN.
- FSM and datapath stay in fetch_unit.

Test Plan:
- Reset, PC register at 0, memory acks after 2 cycles with 0x11111111.
  - Expect imem_addr=0, instr_valid with instr=0x11111111, instr_pc=0.
  - instr_ready=1 → upd_pc pulse with pc_next=4; next request at address 4.
- instr_ready held low 5 cycles in HOLD.
  - instr stable; no upd_pc; single handshake after release.
  - With FETCH_STATS_EN, stall_count includes those 5 cycles.
- br_taken with br_target=0x100 while in WAIT.
  - upd_pc with pc_next=0x100; late ack data discarded, never valid; next imem_addr=0x100.
- br_taken and handshake in the same cycle.
  - pc_next=br_target (not pc+4); fetch_count+1; next fetch from target.
- halt high at handshake of PC=8.
  - halted=1; no further imem_req for 20 cycles; br_taken ignored.
  - rst returns to REQ at the PC register value.
- PC register preset to 0xFFFFFFFC, handshake.
  - pc_next=0x00000000 (wrap).
- Assert rst during WAIT.
  - All outputs return to reset values; a stale ack is not captured.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit.
// Counter helper is used by the optional statistics block.
package fetch_pkg;

    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_INSTR_W = 32;
    localparam int DEF_PC_INC  = 4;

    typedef enum logic [2:0] {
        REQ,
        WAIT,
        HOLD,
        DRAIN,
        HALTED
    } fetch_state_e;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/fetch_stats.sv
// Saturating fetch/stall event counters for the fetch unit.
// Built only when FETCH_STATS_EN is defined.
module fetch_stats
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        hs_i,
    input  logic        stall_i,
    output logic [31:0] fetch_count_o,
    output logic [31:0] stall_count_o
);

    logic [31:0] fc_q, fc_d;
    logic [31:0] sc_q, sc_d;

    always_comb begin
        fc_d = fc_q;
        sc_d = sc_q;
        if (hs_i)    fc_d = sat_inc(fc_q);
        if (stall_i) sc_d = sat_inc(sc_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fc_q <= '0;
            sc_q <= '0;
        end else begin
            fc_q <= fc_d;
            sc_q <= sc_d;
        end
    end

    assign fetch_count_o = fc_q;
    assign stall_count_o = sc_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC -> imem read -> held instruction for decode, plus next-PC.
// Define FETCH_STATS_EN to add fetch_count/stall_count outputs.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int INSTR_W = DEF_INSTR_W,
    parameter int PC_INC  = DEF_PC_INC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  pc_cur,
    output logic               upd_pc,
    output logic [ADDR_W-1:0]  pc_next,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               br_taken,
    input  logic [ADDR_W-1:0]  br_target,
    input  logic               halt,
    output logic               halted
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]        fetch_count,
    output logic [31:0]        stall_count
`endif
);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  ipc_q, ipc_d;

    logic              req;
    logic              upd;
    logic [ADDR_W-1:0] pnext;
    logic              hs;
    logic              stall;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        req     = 1'b0;
        upd     = 1'b0;
        pnext   = '0;
        hs      = 1'b0;
        stall   = 1'b0;

        unique case (state_q)
            REQ: begin
                if (halt) begin
                    state_d = HALTED;
                end else begin
                    req    = 1'b1;
                    addr_d = pc_cur;
                    if (imem_ack) begin
                        if (br_taken) begin
                            state_d = REQ;
                        end else begin
                            instr_d = imem_rdata;
                            ipc_d   = pc_cur;
                            state_d = HOLD;
                        end
                    end else begin
                        state_d = br_taken ? DRAIN : WAIT;
                    end
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (imem_ack) begin
                    if (br_taken) begin
                        state_d = REQ;
                    end else begin
                        instr_d = imem_rdata;
                        ipc_d   = addr_q;
                        state_d = HOLD;
                    end
                end else if (br_taken) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                stall = 1'b1;
                if (imem_ack) state_d = REQ;
            end
            HOLD: begin
                if (instr_ready) begin
                    hs      = 1'b1;
                    upd     = 1'b1;
                    pnext   = pc_cur + ADDR_W'(PC_INC);
                    state_d = (halt && !br_taken) ? HALTED : REQ;
                end else begin
                    stall = 1'b1;
                    if (br_taken) state_d = REQ;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = REQ;
            end
        endcase

        // A redirect overrides the sequential step in every live state
        if (br_taken && state_q != HALTED) begin
            upd   = 1'b1;
            pnext = br_target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= REQ;
            addr_q  <= '0;
            instr_q <= '0;
            ipc_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
        end
    end

    // Strobes are forced low while reset is held, even though REQ is the reset state
    assign imem_req    = req & ~rst;
    assign upd_pc      = upd & ~rst;
    assign pc_next     = rst ? '0 : pnext;
    assign imem_addr   = (state_q == REQ) ? pc_cur : addr_q;
    assign instr       = instr_q;
    assign instr_pc    = ipc_q;
    assign instr_valid = (state_q == HOLD);
    assign halted      = (state_q == HALTED);

`ifdef FETCH_STATS_EN
    fetch_stats u_stats (
        .clk           (clk),
        .rst           (rst),
        .hs_i          (hs & ~rst),
        .stall_i       (stall & ~rst),
        .fetch_count_o (fetch_count),
        .stall_count_o (stall_count)
    );
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: PC register and memory models
// live here; instruction stream expectations come from a PC-sequence model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_q = '0;
    logic        upd_pc;
    logic [31:0] pc_next;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = '0;
    logic        halt = 1'b0;
    logic        halted;
`ifdef FETCH_STATS_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .pc_cur      (pc_q),
        .upd_pc      (upd_pc),
        .pc_next     (pc_next),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .halt        (halt),
        .halted      (halted)
`ifdef FETCH_STATS_EN
        ,
        .fetch_count (fetch_count),
        .stall_count (stall_count)
`endif
    );

    int npass = 0;
    int ntot  = 0;

    // reference model state
    logic [31:0] exp_pc = '0;
    logic        exp_halt = 1'b0;
    int          nhs = 0;
    int          nstall = 0;

    // memory model state
    int          lat = 1;
    logic        mbusy = 1'b0;
    int          mcnt = 0;
    logic [31:0] maddr = '0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'h1111_1111;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    task automatic cycle(input logic br, input logic [31:0] tgt,
                         input logic rdy, input logic hlt);
        logic        hs;
        logic        u;
        logic [31:0] pn;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        if (mbusy) begin
            if (mcnt == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = memf(maddr);
                mbusy      = 1'b0;
            end else begin
                mcnt--;
            end
        end
        br_taken    = br;
        br_target   = tgt;
        instr_ready = rdy;
        halt        = hlt;
        #1;
        if (imem_req && !mbusy && !imem_ack) begin
            if (lat == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = memf(imem_addr);
            end else begin
                mbusy = 1'b1;
                mcnt  = lat - 1;
                maddr = imem_addr;
            end
        end
        #1;
        hs = instr_valid && rdy;
        if (exp_halt) begin
            chk("halted", 32'(halted), 32'd1);
            chk("halt_req", 32'(imem_req), 32'd0);
            chk("halt_upd", 32'(upd_pc), 32'd0);
            chk("halt_valid", 32'(instr_valid), 32'd0);
        end else begin
            if (imem_req) chk("imem_addr", imem_addr, exp_pc);
            if (instr_valid) begin
                chk("instr_pc", instr_pc, exp_pc);
                chk("instr", instr, memf(exp_pc));
            end
            if (hs || br) begin
                chk("upd_pc", 32'(upd_pc), 32'd1);
                chk("pc_next", pc_next, br ? tgt : exp_pc + 32'd4);
            end else begin
                chk("upd_idle", 32'(upd_pc), 32'd0);
            end
            if (!imem_req && !hs) nstall++;
            if (hs) begin
                nhs++;
                if (hlt && !br) exp_halt = 1'b1;
            end
            if (br) exp_pc = tgt;
            else if (hs) exp_pc = exp_pc + 32'd4;
        end
        u  = upd_pc;
        pn = pc_next;
        @(posedge clk);
        #1;
        if (u) pc_q = pn;
    endtask

    task automatic do_reset(input logic [31:0] pc0, input logic stale);
        @(negedge clk);
        rst         = 1'b1;
        imem_ack    = stale;
        imem_rdata  = 32'hDEAD_BEEF;
        br_taken    = 1'b0;
        instr_ready = 1'b0;
        halt        = 1'b0;
        pc_q        = pc0;
        mbusy       = 1'b0;
        #1;
        chk("rst_upd", 32'(upd_pc), 32'd0);
        chk("rst_pnext", pc_next, 32'd0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_ipc", instr_pc, 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_stale", instr, 32'd0);
        imem_ack = 1'b0;
        rst      = 1'b0;
        exp_pc   = pc0;
        exp_halt = 1'b0;
        nhs      = 0;
        nstall   = 0;
    endtask

    task automatic fetch_one(input int dly, input logic br,
                             input logic [31:0] tgt, input logic hlt);
        for (int i = 0; i < 40 && !instr_valid; i++) cycle(1'b0, '0, 1'b0, 1'b0);
        chk("valid_timeout", 32'(instr_valid), 32'd1);
        for (int i = 0; i < dly; i++) cycle(1'b0, '0, 1'b0, 1'b0);
        cycle(br, tgt, 1'b1, hlt);
    endtask

    task automatic chk_stats();
`ifdef FETCH_STATS_EN
        chk("fetch_count", fetch_count, 32'(nhs));
        chk("stall_count", stall_count, 32'(nstall));
`endif
    endtask

    initial begin
        logic [31:0] t;

        // basic fetch at 0 with 2-cycle memory and 5 stalled HOLD cycles
        lat = 2;
        do_reset(32'h0, 1'b0);
        fetch_one(5, 1'b0, '0, 1'b0);
        chk("pc_after_hs", pc_q, 32'h4);
        chk_stats();

        // redirect while waiting on memory; late data must be dropped
        lat = 3;
        cycle(1'b0, '0, 1'b0, 1'b0);
        cycle(1'b1, 32'h100, 1'b0, 1'b0);
        fetch_one(0, 1'b0, '0, 1'b0);
        chk("pc_after_br", pc_q, 32'h104);

        // redirect coincident with handshake
        lat = 1;
        fetch_one(2, 1'b1, 32'h200, 1'b0);
        chk("pc_br_hs", pc_q, 32'h200);
        fetch_one(0, 1'b0, '0, 1'b0);
        chk_stats();

        // halt at the handshake of PC=8
        do_reset(32'h0, 1'b0);
        fetch_one(0, 1'b0, '0, 1'b0);
        fetch_one(1, 1'b0, '0, 1'b0);
        fetch_one(0, 1'b0, '0, 1'b1);
        chk("halted_set", 32'(halted), 32'd1);
        for (int i = 0; i < 20; i++) begin
            t = $urandom;
            t[1:0] = 2'b00;
            cycle(1'($urandom % 2), t, 1'($urandom % 2), 1'b0);
        end
        chk("pc_frozen", pc_q, 32'hC);
        do_reset(pc_q, 1'b0);
        fetch_one(0, 1'b0, '0, 1'b0);
        chk("pc_resume", pc_q, 32'h10);

        // sequential wrap at the top of the address space
        do_reset(32'hFFFF_FFFC, 1'b0);
        fetch_one(0, 1'b0, '0, 1'b0);
        chk("wrap", pc_q, 32'h0);

        // reset while waiting, stale ack arrives during reset
        lat = 5;
        cycle(1'b0, '0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        do_reset(pc_q, 1'b1);
        lat = 1;
        fetch_one(0, 1'b0, '0, 1'b0);

        // randomized traffic
        do_reset({$urandom_range(0, 1023), 2'b00} & 32'h0000_0FFC, 1'b0);
        for (int i = 0; i < 400; i++) begin
            lat = $urandom_range(0, 3);
            t = $urandom;
            t[1:0] = 2'b00;
            cycle(1'($urandom % 8 == 0), t, 1'($urandom % 3 != 0), 1'b0);
        end
        chk_stats();

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
